ram_dp_clr: RTL and testbench

RAM_DP_CLR -- requirements
Module: ram_dp_clr

---
 rtl/ram_dp_clr.sv | 133 +++++++++++++
 tb/tb_ram_dp_clr.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_clr.sv
// rtl/ram_dp_clr.sv - simple dual-port RAM with byte lanes and a self-clearing sequencer
module ram_dp_clr #(
    parameter int              A   = 10,
    parameter int              D   = 8,
    parameter int              L   = 8,
    parameter int              RDW = 0,
    parameter logic [D-1:0]    CLR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [A-1:0]     wr_addr,
    input  logic [D-1:0]     wr_data,
    input  logic [D/L-1:0]   wr_be,
    input  logic             rd_en,
    input  logic [A-1:0]     rd_addr,
    output logic [D-1:0]     rd_data,
    output logic             rd_valid,
    input  logic             clr_req,
    output logic             busy
);

    localparam int          N     = D / L;
    localparam int          DEPTH = 1 << A;
    localparam logic [A-1:0] LAST = '1;

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [A-1:0]   cnt_q, cnt_d;
    logic [D-1:0]   mem_q [DEPTH];
    logic [D-1:0]   rd_data_q, rd_data_d;
    logic           rd_valid_q;

    logic           busy_c;
    logic           rd_accept;
    logic           mem_we;
    logic [A-1:0]   mem_waddr;
    logic [D-1:0]   mem_wdata;
    logic [N-1:0]   mem_wbe;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + A'(1);
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        busy_c = (state_q == S_CLEAR);
    end

    // The clear sequencer owns the write port while busy; user requests are dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
        if (!reset) begin
            if (busy_c) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = CLR;
                mem_wbe   = '1;
            end else begin
                mem_we    = wr_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < N; i++) begin
                if (mem_wbe[i]) begin
                    mem_q[mem_waddr][i*L +: L] <= mem_wdata[i*L +: L];
                end
            end
        end
    end

    assign rd_accept = rd_en && !busy_c;

    // With RDW=1 a colliding write is forwarded lane by lane into the read result.
    always_comb begin
        rd_data_d = mem_q[rd_addr];
        if ((RDW != 0) && wr_en && (wr_addr == rd_addr)) begin
            for (int i = 0; i < N; i++) begin
                if (wr_be[i]) begin
                    rd_data_d[i*L +: L] = wr_data[i*L +: L];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_c;

endmodule

// File: tb/tb_ram_dp_clr.sv
// tb/tb_ram_dp_clr.sv - randomized self-checking bench for ram_dp_clr (RDW=0 and RDW=1 instances)
module tb_ram_dp_clr;

    localparam logic [15:0] CLRV = 16'h0000;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        clr_req;
    logic [15:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;

    // Reference model: word array, words still to clear, expected read outputs.
    logic [15:0] mem_m [16];
    int          clr_left;
    logic [15:0] er0, er1;
    logic        ev;

    ram_dp_clr #(.A(4), .D(16), .L(8), .RDW(0), .CLR(CLRV)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .clr_req(clr_req), .busy(busy0)
    );

    ram_dp_clr #(.A(4), .D(16), .L(8), .RDW(1), .CLR(CLRV)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .clr_req(clr_req), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0; clr_req = 1'b0;
    endtask

    task automatic tick();
        if (reset) begin
            clr_left = 16; ev = 1'b0; er0 = '0; er1 = '0;
        end else if (clr_left > 0) begin
            mem_m[16 - clr_left] = CLRV;
            clr_left--;
            ev = 1'b0;
        end else begin
            ev = rd_en;
            if (rd_en) begin
                er0 = mem_m[rd_addr];
                er1 = er0;
                if (wr_en && wr_addr == rd_addr)
                    for (int i = 0; i < 2; i++) if (wr_be[i]) er1[i*8 +: 8] = wr_data[i*8 +: 8];
            end
            if (wr_en)
                for (int i = 0; i < 2; i++) if (wr_be[i]) mem_m[wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
            if (clr_req) clr_left = 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        int vhi;
        reset = 1'b1;
        tick();
        checks++;
        if ({busy0, rd_valid0, rd_data0, busy1, rd_valid1, rd_data1} !== {1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_state got busy=%b v=%b d=%h busy1=%b v1=%b d1=%h want busy=1 v=0 d=0000",
                     busy0, rd_valid0, rd_data0, busy1, rd_valid1, rd_data1);
        end
        reset = 1'b0;
        wr_en = 1'b1; wr_be = 2'b11; rd_en = 1'b1;
        n = 0; vhi = 0;
        do begin
            wr_addr = 4'($urandom_range(0, 15)); wr_data = 16'($urandom) | 16'h0101;
            rd_addr = 4'($urandom_range(0, 15));
            tick();
            n++;
            if (rd_valid0 || rd_valid1) vhi++;
        end while (busy0 && n < 40);
        idle();
        checks++;
        if (n != 16 || vhi != 0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL busy_len got %0d cycles (valid_hi=%0d busy1=%b) want 16 cycles valid_hi=0", n, vhi, busy1);
        end
    endtask

    task automatic test_clear_reads();
        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            tick();
            checks++;
            if ({rd_valid0, rd_data0, rd_valid1, rd_data1} !== {1'b1, CLRV, 1'b1, CLRV}) begin
                errors++;
                $display("FAIL clear_read addr=%0d got v=%b d=%h v1=%b d1=%h want v=1 d=%h",
                         a, rd_valid0, rd_data0, rd_valid1, rd_data1, CLRV);
            end
        end
        idle();
    endtask

    task automatic test_byte_lanes();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hABCD; wr_be = 2'b11; tick();
        wr_data = 16'h1200; wr_be = 2'b10; tick();
        idle(); rd_en = 1'b1; rd_addr = 4'd3; tick();
        checks++;
        if (rd_data0 !== 16'h12CD || rd_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL lane_merge got %h v=%b want 12cd v=1", rd_data0, rd_valid0);
        end
        idle(); wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hFFFF; wr_be = 2'b00; tick();
        idle(); rd_en = 1'b1; rd_addr = 4'd3; tick();
        checks++;
        if (rd_data0 !== 16'h12CD || rd_data1 !== 16'h12CD) begin
            errors++;
            $display("FAIL be_zero got %h/%h want 12cd", rd_data0, rd_data1);
        end
        idle();
    endtask

    task automatic test_rdw();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1111; wr_be = 2'b11; tick();
        wr_data = 16'h2222; rd_en = 1'b1; rd_addr = 4'd5; tick();
        checks++;
        if (rd_data0 !== 16'h1111 || rd_data1 !== 16'h2222) begin
            errors++;
            $display("FAIL rdw_collide got rdw0=%h rdw1=%h want 1111/2222", rd_data0, rd_data1);
        end
        idle(); rd_en = 1'b1; rd_addr = 4'd5; tick();
        checks++;
        if (rd_data0 !== 16'h2222 || rd_data1 !== 16'h2222) begin
            errors++;
            $display("FAIL rdw_after got %h/%h want 2222", rd_data0, rd_data1);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int a = 1; a <= 3; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_data = 16'($urandom); wr_be = 2'b11; tick();
        end
        idle();
        for (int a = 1; a <= 3; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a); tick();
            checks++;
            if (rd_valid0 !== 1'b1 || rd_data0 !== mem_m[a]) begin
                errors++;
                $display("FAIL b2b_read addr=%0d got v=%b d=%h want v=1 d=%h", a, rd_valid0, rd_data0, mem_m[a]);
            end
        end
        idle(); tick();
        checks++;
        if (rd_valid0 !== 1'b0 || rd_data0 !== mem_m[3] || rd_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold got v=%b d=%h want v=0 d=%h", rd_valid0, rd_data0, mem_m[3]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = 16'($urandom); wr_be = 2'($urandom);
            rd_en = 1'($urandom);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
            clr_req = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if ({busy0, rd_valid0, rd_data0, busy1, rd_valid1, rd_data1} !==
                {(clr_left > 0), ev, er0, (clr_left > 0), ev, er1}) begin
                errors++;
                $display("FAIL random c=%0d got busy=%b v=%b d0=%h d1=%h want busy=%b v=%b d0=%h d1=%h",
                         c, busy0, rd_valid0, rd_data0, rd_data1, (clr_left > 0), ev, er0, er1);
            end
        end
        idle();
        while (clr_left > 0) tick();
    endtask

    task automatic test_clear_req();
        int vhi;
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_data = 16'($urandom) | 16'h0101; wr_be = 2'b11; tick();
        end
        idle(); clr_req = 1'b1; tick();
        vhi = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'($urandom); wr_data = 16'hFFFF; wr_be = 2'b11;
            rd_en = 1'b1; rd_addr = 4'($urandom); clr_req = 1'($urandom);
            tick();
            if (rd_valid0 || rd_valid1) vhi++;
            checks++;
            if (busy0 !== (i < 15) || busy1 !== busy0) begin
                errors++;
                $display("FAIL clr_busy i=%0d got %b/%b want %b", i, busy0, busy1, (i < 15));
            end
        end
        idle();
        checks++;
        if (vhi != 0) begin
            errors++;
            $display("FAIL clr_valid got %0d valid cycles want 0", vhi);
        end
        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a); tick();
            checks++;
            if (rd_data0 !== CLRV || rd_data1 !== CLRV || rd_valid0 !== 1'b1) begin
                errors++;
                $display("FAIL clr_read addr=%0d got %h/%h v=%b want %h v=1", a, rd_data0, rd_data1, rd_valid0, CLRV);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h5A5A; wr_be = 2'b11; tick();
        idle(); rd_en = 1'b1; rd_addr = 4'd7; tick();
        idle(); clr_req = 1'b1; tick();
        clr_req = 1'b0;
        repeat (9) tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        checks++;
        if (rd_data0 !== 16'h0 || rd_valid0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL midclr_reset got d=%h v=%b busy=%b want d=0000 v=0 busy=1", rd_data0, rd_valid0, busy0);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (busy0 && n < 40);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL midclr_len got %0d cycles want 16", n);
        end
        rd_en = 1'b1; rd_addr = 4'd9; tick();
        checks++;
        if (rd_data0 !== CLRV || rd_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL midclr_read got %h v=%b want %h v=1", rd_data0, rd_valid0, CLRV);
        end
        idle();
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem_m[a] = 'x;
        clr_left = 16; ev = 1'b0; er0 = '0; er1 = '0;
        idle();
        reset = 1'b1;
        tick();
        test_reset();
        test_clear_reads();
        test_byte_lanes();
        test_rdw();
        test_back_to_back();
        test_random();
        test_clear_req();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
